// File: rtl/control_if.sv
// Decoder bus: instruction/flag in, datapath controls and sticky illegal out.
interface control_if;
  logic [31:0] instr;
  logic        zero;
  logic [1:0]  imm_sel;
  logic        regrw;
  logic        alusrc;
  logic [2:0]  aluop;
  logic        memrw;
  logic        pcsrc;
  logic        wb;
  logic        illegal;

  modport master (
    output instr, zero,
    input  imm_sel, regrw, alusrc, aluop, memrw, pcsrc, wb, illegal
  );

  modport slave (
    input  instr, zero,
    output imm_sel, regrw, alusrc, aluop, memrw, pcsrc, wb, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Main decoder for a single-cycle RV32I-subset datapath.
// Controls are combinational from instr/zero; only the illegal flag is stored.
module control_unit (
  input  logic      clk,
  input  logic      rst,
  control_if.slave  bus
);
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero;
  logic       unused_instr_bits;

  logic [1:0] dec_imm_sel;
  logic       dec_regrw, dec_alusrc, dec_memrw, dec_pcsrc, dec_wb, dec_bad;
  logic [2:0] dec_aluop;
  logic       illegal_q, illegal_d;

  assign opcode  = bus.instr[6:0];
  assign funct3  = bus.instr[14:12];
  assign funct7  = bus.instr[31:25];
  assign f7_zero = (funct7 == 7'b0000000);
  // Register/immediate fields are consumed by the datapath, not here.
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  // Instruction decode; an unsupported encoding collapses to an all-zero NOP.
  // zero is only looked at inside BRANCH so other pcsrc values never go X.
  always_comb begin
    dec_imm_sel = 2'b00;
    dec_regrw   = 1'b0;
    dec_alusrc  = 1'b0;
    dec_aluop   = ALU_ADD;
    dec_memrw   = 1'b0;
    dec_pcsrc   = 1'b0;
    dec_wb      = 1'b0;
    dec_bad     = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        dec_regrw  = 1'b1;
        dec_alusrc = 1'b1;
        case (funct3)
          3'b000: dec_aluop = ALU_ADD;
          3'b010: dec_aluop = ALU_SLT;
          3'b011: dec_aluop = ALU_SLTU;
          3'b110: dec_aluop = ALU_OR;
          3'b111: dec_aluop = ALU_AND;
          3'b001: begin dec_aluop = ALU_SLL; dec_bad = !f7_zero; end
          3'b101: begin dec_aluop = ALU_SRL; dec_bad = !f7_zero; end
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec_regrw = 1'b1;
        case (funct3)
          3'b000: begin
            if (f7_zero)                      dec_aluop = ALU_ADD;
            else if (funct7 == 7'b0100000)    dec_aluop = ALU_SUB;
            else                              dec_bad   = 1'b1;
          end
          3'b001: begin dec_aluop = ALU_SLL;  dec_bad = !f7_zero; end
          3'b010: begin dec_aluop = ALU_SLT;  dec_bad = !f7_zero; end
          3'b011: begin dec_aluop = ALU_SLTU; dec_bad = !f7_zero; end
          3'b101: begin dec_aluop = ALU_SRL;  dec_bad = !f7_zero; end
          3'b110: begin dec_aluop = ALU_OR;   dec_bad = !f7_zero; end
          3'b111: begin dec_aluop = ALU_AND;  dec_bad = !f7_zero; end
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_regrw  = 1'b1;
        dec_alusrc = 1'b1;
        dec_wb     = 1'b1;
        dec_bad    = (funct3 != 3'b010);
      end
      OPC_STORE: begin
        dec_imm_sel = 2'b01;
        dec_alusrc  = 1'b1;
        dec_memrw   = 1'b1;
        dec_bad     = (funct3 != 3'b010);
      end
      OPC_BRANCH: begin
        dec_imm_sel = 2'b10;
        case (funct3)
          3'b000: begin dec_aluop = ALU_SUB;  dec_pcsrc =  bus.zero; end
          3'b001: begin dec_aluop = ALU_SUB;  dec_pcsrc = !bus.zero; end
          3'b100: begin dec_aluop = ALU_SLT;  dec_pcsrc = !bus.zero; end
          3'b101: begin dec_aluop = ALU_SLT;  dec_pcsrc =  bus.zero; end
          3'b110: begin dec_aluop = ALU_SLTU; dec_pcsrc = !bus.zero; end
          3'b111: begin dec_aluop = ALU_SLTU; dec_pcsrc =  bus.zero; end
          default: dec_bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_imm_sel = 2'b11;
        dec_pcsrc   = 1'b1;
      end
      OPC_JALR: begin
        dec_alusrc = 1'b1;
        dec_pcsrc  = 1'b1;
        dec_bad    = (funct3 != 3'b000);
      end
      default: dec_bad = 1'b1;
    endcase
    if (dec_bad) begin
      dec_imm_sel = 2'b00;
      dec_regrw   = 1'b0;
      dec_alusrc  = 1'b0;
      dec_aluop   = ALU_ADD;
      dec_memrw   = 1'b0;
      dec_pcsrc   = 1'b0;
      dec_wb      = 1'b0;
    end
  end

  // Sticky flag next state: reset clears, any illegal decode sets.
  always_comb begin
    illegal_d = illegal_q | dec_bad;
    if (rst) illegal_d = 1'b0;
  end

  // Sticky illegal-instruction register.
  always_ff @(posedge clk) begin
    illegal_q <= illegal_d;
  end

  // Side-effecting enables are held off while reset is asserted.
  assign bus.imm_sel = dec_imm_sel;
  assign bus.regrw   = dec_regrw & !rst;
  assign bus.alusrc  = dec_alusrc;
  assign bus.aluop   = dec_aluop;
  assign bus.memrw   = dec_memrw & !rst;
  assign bus.pcsrc   = dec_pcsrc & !rst;
  assign bus.wb      = dec_wb;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Control vector order:
// {imm_sel[1:0], regrw, alusrc, aluop[2:0], memrw, pcsrc, wb}
module tb_control_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  control_if bus_if ();

  control_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  logic [9:0] ctl;
  assign ctl = {bus_if.imm_sel, bus_if.regrw, bus_if.alusrc, bus_if.aluop,
                bus_if.memrw, bus_if.pcsrc, bus_if.wb};

  typedef struct {
    string      name;
    logic [31:0] instr;
    logic        zero;
    logic [9:0]  exp;
  } vec_t;

  // Drive inputs away from the active edge and let decode settle.
  task automatic drive(input logic [31:0] i, input logic z);
    @(negedge clk);
    bus_if.instr = i;
    bus_if.zero  = z;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h00450693, 1'b0);
    n_total++;
    if (ctl !== 10'b00_0_1_000_0_0_0)
      $display("FAIL rst_addi_gated: got %b want %b", ctl, 10'b00_0_1_000_0_0_0);
    else n_pass++;
    drive(32'hfc1ff06f, 1'b0);
    n_total++;
    if (ctl !== 10'b11_0_0_000_0_0_0)
      $display("FAIL rst_jal_gated: got %b want %b", ctl, 10'b11_0_0_000_0_0_0);
    else n_pass++;
    drive(32'h00d6a023, 1'b0);
    n_total++;
    if (bus_if.memrw !== 1'b0)
      $display("FAIL rst_sw_memrw: got %b want 0", bus_if.memrw);
    else n_pass++;
    // Illegal instruction during reset must not set the flag.
    drive(32'h00000000, 1'b0);
    @(posedge clk); #1;
    n_total++;
    if (bus_if.illegal !== 1'b0)
      $display("FAIL rst_illegal_clear: got %b want 0", bus_if.illegal);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic run_table(input vec_t v[]);
    foreach (v[k]) begin
      drive(v[k].instr, v[k].zero);
      n_total++;
      if (ctl !== v[k].exp)
        $display("FAIL %s: got %b want %b", v[k].name, ctl, v[k].exp);
      else n_pass++;
    end
  endtask

  task automatic test_op_imm();
    vec_t v[] = '{
      '{"addi",      32'h00450693, 1'b0, 10'b00_1_1_000_0_0_0},
      '{"addi_neg",  32'hfff78793, 1'b0, 10'b00_1_1_000_0_0_0},
      '{"slli",      32'h00279793, 1'b0, 10'b00_1_1_010_0_0_0},
      '{"srli",      32'h0057d793, 1'b0, 10'b00_1_1_101_0_0_0},
      '{"andi",      32'h0ff7f793, 1'b0, 10'b00_1_1_111_0_0_0}
    };
    run_table(v);
  endtask

  task automatic test_branch();
    vec_t v[] = '{
      '{"bltu_z0",   32'h00b76463, 1'b0, 10'b10_0_0_100_0_1_0},
      '{"bltu_z1",   32'h00b76463, 1'b1, 10'b10_0_0_100_0_0_0},
      '{"bge_z0",    32'h01185a63, 1'b0, 10'b10_0_0_011_0_0_0},
      '{"bge_z1",    32'h01185a63, 1'b1, 10'b10_0_0_011_0_1_0},
      '{"bne_z0",    32'hfe0796e3, 1'b0, 10'b10_0_0_001_0_1_0},
      '{"beq_z1",    32'h00b70463, 1'b1, 10'b10_0_0_001_0_1_0},
      '{"beq_z0",    32'h00b70463, 1'b0, 10'b10_0_0_001_0_0_0}
    };
    run_table(v);
  endtask

  task automatic test_mem();
    vec_t v[] = '{
      '{"sw_zx",     32'h00d6a023, 1'bx, 10'b01_0_1_000_1_0_0},
      '{"lw_zx",     32'h0006a803, 1'bx, 10'b00_1_1_000_0_0_1},
      '{"addi_zx",   32'h00450693, 1'bx, 10'b00_1_1_000_0_0_0}
    };
    run_table(v);
  endtask

  task automatic test_arith_jump();
    vec_t v[] = '{
      '{"add",       32'h00b708b3, 1'b0, 10'b00_1_0_000_0_0_0},
      '{"sub",       32'h40b70733, 1'b0, 10'b00_1_0_001_0_0_0},
      '{"sltu",      32'h00b737b3, 1'b0, 10'b00_1_0_100_0_0_0},
      '{"jalr",      32'h00008067, 1'b0, 10'b00_0_1_000_0_1_0},
      '{"jal_zx",    32'hfc1ff06f, 1'bx, 10'b11_0_0_000_0_1_0}
    };
    run_table(v);
  endtask

  task automatic test_illegal_decode();
    vec_t v[] = '{
      '{"ill_zero",    32'h00000000, 1'b1, 10'b0},
      '{"ill_br010",   32'h00b72463, 1'b0, 10'b0},
      '{"ill_srai",    32'h4057d793, 1'b0, 10'b0},
      '{"ill_op_f7",   32'h40b71733, 1'b0, 10'b0},
      '{"ill_lb",      32'h00068803, 1'b0, 10'b0},
      '{"ill_sh",      32'h00d69023, 1'b0, 10'b0},
      '{"ill_jalr001", 32'h00009067, 1'b0, 10'b0}
    };
    run_table(v);
  endtask

  task automatic test_illegal_sticky();
    rst = 1'b1;
    drive(32'h00450693, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(32'h00450693, 1'b0);
    @(posedge clk); #1;
    n_total++;
    if (bus_if.illegal !== 1'b0)
      $display("FAIL sticky_legal_stays0: got %b want 0", bus_if.illegal);
    else n_pass++;
    drive(32'h00000000, 1'b0);
    n_total++;
    if (bus_if.illegal !== 1'b0 || ctl !== 10'b0)
      $display("FAIL sticky_pre_edge: got ill=%b ctl=%b want ill=0 ctl=0", bus_if.illegal, ctl);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus_if.illegal !== 1'b1 || ctl !== 10'b0)
      $display("FAIL sticky_set: got ill=%b ctl=%b want ill=1 ctl=0", bus_if.illegal, ctl);
    else n_pass++;
    drive(32'h00b708b3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus_if.illegal !== 1'b1)
      $display("FAIL sticky_hold: got %b want 1", bus_if.illegal);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (bus_if.illegal !== 1'b1 || bus_if.regrw !== 1'b0)
      $display("FAIL sticky_rst_pre_edge: got ill=%b regrw=%b want ill=1 regrw=0", bus_if.illegal, bus_if.regrw);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if (bus_if.illegal !== 1'b0)
      $display("FAIL sticky_cleared: got %b want 0", bus_if.illegal);
    else n_pass++;
    #1;
    n_total++;
    if (bus_if.regrw !== 1'b1)
      $display("FAIL post_rst_regrw: got %b want 1", bus_if.regrw);
    else n_pass++;
  endtask

  initial begin
    rst          = 1'b1;
    bus_if.instr = 32'h0;
    bus_if.zero  = 1'b0;
    test_reset();
    test_op_imm();
    test_branch();
    test_mem();
    test_arith_jump();
    test_illegal_decode();
    test_illegal_sticky();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for a single-cycle RV32I-subset datapath. Takes the fetched 32-bit instruction and the ALU zero flag.
- Produces these datapath controls: immediate format select, register write enable, ALU operand-B select, ALU operation, data-memory write enable, PC-source select and write-back select.
- Decode is combinational. The only state is a sticky illegal-instruction flag, plus reset gating of side-effecting enables.

Parameters:
none

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
instr  input  32  current instruction word
zero  input  1  ALU result-equals-zero flag; consulted only for branches
imm_sel  output  2  immediate format: 00 I, 01 S, 10 B, 11 J
regrw  output  1  register-file write enable
alusrc  output  1  ALU operand B: 0 rs2, 1 immediate
aluop  output  3  000 ADD, 001 SUB, 010 SLL, 011 SLT, 100 SLTU, 101 SRL, 110 OR, 111 AND
memrw  output  1  data-memory write enable (1 = store)
pcsrc  output  1  0 = PC+4, 1 = branch/jump target
wb  output  1  write-back source: 0 ALU result, 1 memory read data
illegal  output  1  sticky flag: an unsupported instruction was decoded

Behaviour:
- Zero latency: all outputs except illegal follow instr/zero combinationally within the same cycle.
- Decoding uses opcode instr[6:0], funct3 instr[14:12] and funct7 instr[31:25].
- Default for every output is 0.
- OP-IMM (0010011): regrw=1, alusrc=1, imm_sel=00.
  - aluop from funct3: 000→ADD, 010→SLT, 011→SLTU, 110→OR, 111→AND.
  - 001 with funct7=0000000→SLL.
  - 101 with funct7=0000000→SRL.
  - Any other funct3/funct7 combination is illegal.
- OP (0110011): regrw=1, alusrc=0.
  - funct3 000 with funct7 0000000→ADD; with funct7 0100000→SUB.
  - 001→SLL, 010→SLT, 011→SLTU, 101→SRL, 110→OR, 111→AND, each requiring funct7=0000000.
  - Anything else is illegal.
- LOAD (0000011), funct3=010 only: regrw=1, alusrc=1, imm_sel=00, aluop=ADD, wb=1.
- STORE (0100011), funct3=010 only: memrw=1, alusrc=1, imm_sel=01, aluop=ADD, regrw=0.
- BRANCH (1100011): imm_sel=10, alusrc=0, regrw=0. aluop and taken condition by funct3:
  - beq 000: SUB, taken when zero=1.
  - bne 001: SUB, taken when zero=0.
  - blt 100: SLT, taken when zero=0.
  - bge 101: SLT, taken when zero=1.
  - bltu 110: SLTU, taken when zero=0.
  - bgeu 111: SLTU, taken when zero=1.
  - funct3 010 and 011 are illegal.
  - pcsrc = taken.
- JAL (1101111): imm_sel=11, pcsrc=1, regrw=0. Link write is not supported; these are pure jumps.
- JALR (1100111), funct3=000: imm_sel=00, alusrc=1, aluop=ADD, pcsrc=1, regrw=0.
- Any other opcode, including all-zero instr, is illegal.
- Illegal decode outputs: all outputs 0 (a NOP); no write, no PC redirect.
- For non-branch instructions pcsrc must be a clean 0 or 1 independent of zero, including when zero is X.
- illegal register: at a rising clk edge with rst=1 it is cleared to 0. Otherwise it is set to 1 at a rising edge when the current instr decodes illegal. It stays set until reset.
- While rst=1, regrw, memrw and pcsrc are forced to 0 combinationally. Other outputs still decode normally.
- Reset values: illegal=0; regrw=memrw=pcsrc=0 during reset.

Test Plan:
- instr=00450693 (addi), zero=0 -> regrw=1, alusrc=1, imm_sel=00, aluop=000, memrw=0, pcsrc=0, wb=0. Same outputs for fff78793.
- instr=00b76463 (bltu) with zero=0 -> imm_sel=10, aluop=100, alusrc=0, regrw=0, pcsrc=1. With zero=1 -> pcsrc=0.
- instr=01185a63 (bge) with zero=0 -> aluop=011, pcsrc=0. instr=fe0796e3 (bne) with zero=0 -> aluop=001, pcsrc=1.
- instr=00d6a023 (sw) -> memrw=1, imm_sel=01, alusrc=1, regrw=0. instr=0006a803 (lw) -> regrw=1, wb=1, alusrc=1. Both with zero=X -> pcsrc=0, never X.
- Arithmetic, shift and jumps:
  - 00b708b3 (add) -> aluop=000, alusrc=0, regrw=1.
  - 00279793 (slli) -> aluop=010.
  - 00008067 (jalr) -> pcsrc=1, regrw=0, alusrc=1.
  - fc1ff06f (jal) -> imm_sel=11, pcsrc=1.
- rst=1 for one edge, then instr=00000000 for one clock -> illegal rises to 1 after that edge with all controls 0. illegal stays 1 on later legal instructions, and returns to 0 only after a reset edge. Outputs regrw/memrw/pcsrc read 0 while rst=1.
